// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: state encoding, shift directions
// and default geometry.
package shift_seq_defs;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  // 2'd3 is never entered deliberately; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the pipeline stall logic (master) and the
// shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  // Handshake: start is sampled only while the sequencer is idle (busy=0).
  // The operand fields are captured on that same edge and are don't-care
  // otherwise. busy rises the cycle after acceptance; done pulses for one
  // cycle with result valid, and result then holds until the next accepted
  // start. There is no back-pressure on done.
  logic               start;
  logic               lr_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;

  modport master (
    output start, lr_shift, shamt, data_in,
    input  result, busy, done
  );

  modport slave (
    input  start, lr_shift, shamt, data_in,
    output result, busy, done
  );

endinterface

// File: rtl/shift_sequencer_shift_stage_1.sv
// Single combinational 1-bit shift stage: logical left or arithmetic right,
// with a bypass that passes the operand through unchanged.
module shift_stage_1
  import shift_seq_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             bypass,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    if (!bypass) begin
      if (dir == DIR_RIGHT) begin
        dout = {din[WIDTH-1], din[WIDTH-1:1]};
      end else begin
        dout = {din[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per clock through shift_stage_1.
// Optional SHIFT_SEQ_EARLY_EXIT_EN finishes early once the working value is fixed.
module shift_sequencer
  import shift_seq_defs::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  shift_sequencer_if.slave    bus,
  output state_t              dbg_state
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   stage_out;
  logic               stage_bypass;
  logic               early_exit;

  assign stage_bypass = (state_q != ST_SHIFT);

  shift_stage_1 #(.WIDTH(WIDTH)) u_stage (
    .din    (work_q),
    .dir    (dir_q),
    .bypass (stage_bypass),
    .dout   (stage_out)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Judged on the value entering this cycle, so at least one SHIFT cycle runs.
  assign early_exit = (work_q == '0) || ((dir_q == DIR_RIGHT) && (work_q == '1));
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    dir_d    = dir_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          work_d  = bus.data_in;
          count_d = bus.shamt;
          dir_d   = bus.lr_shift;
          state_d = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        work_d  = stage_out;
        count_d = count_q - SHAMT_W'(1);
        if ((count_q == SHAMT_W'(1)) || early_exit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Result is captured only on entry to DONE, then held through IDLE.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      result_d = work_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      dir_q    <= DIR_LEFT;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.done   = (state_q == ST_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_shift_sequencer;
  import shift_seq_defs::*;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic   clock;
  logic   reset;
  state_t dbg_state;
  int     checks;
  int     failures;
  logic [31:0] exp_q[$];

  shift_sequencer_if bus();

  shift_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        lr;
    logic [4:0]  sh;
    logic [31:0] din;
    logic [31:0] exp_res;
    int          exp_lat;
    int          pulse_cyc;
    bit          start_in_done;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] model_result(input logic lr, input int sh, input logic [31:0] d);
    logic [31:0] r;
    if (lr) r = 32'($signed(d) >>> sh);
    else    r = d << sh;
    return r;
  endfunction

  // Cycle count from start-sample to done; with early exit, SHIFT cycle j
  // ends the run when the value after j-1 shifts is already a fixed point.
  function automatic int model_latency(input logic lr, input int sh, input logic [31:0] d);
    int cycles;
    logic [31:0] v;
    cycles = sh;
    if (EE) begin
      for (int j = 1; j <= sh; j++) begin
        v = model_result(lr, j - 1, d);
        if ((v == 32'h0) || (lr && (v == 32'hFFFF_FFFF))) begin
          cycles = j;
          break;
        end
      end
    end
    return cycles + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver: issue one operation and follow it to completion
  task automatic run_op(input string name, input logic lr, input logic [4:0] sh,
                        input logic [31:0] din, input logic [31:0] exp_res,
                        input int exp_lat, input int pulse_cyc, input bit start_in_done);
    int cyc;
    int busy_cnt;
    bit seen;
    logic [31:0] exp_v;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.lr_shift = lr;
    bus.shamt    = sh;
    bus.data_in  = din;
    exp_q.push_back(exp_res);
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.lr_shift = 1'($urandom_range(0, 1));
    bus.shamt    = 5'($urandom_range(0, 31));
    bus.data_in  = $urandom;
    cyc = 1;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc <= 70) begin
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (pulse_cyc != 0 && cyc == pulse_cyc) begin
          bus.start   = 1'b1;
          bus.data_in = 32'hFFFF_FFFF;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
      end
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    else exp_v = 32'hx;
    check({name, " result"}, bus.result, exp_v);
    if (start_in_done) begin
      bus.start   = 1'b1;
      bus.data_in = 32'h1234_5678;
      bus.shamt   = 5'd3;
    end
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check({name, " idle_done"}, 32'(bus.done), 32'd0);
    check({name, " idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, " idle_state"}, 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clock);
    #1;
    check({name, " held_result"}, bus.result, exp_res);
  endtask

  initial begin
    logic        r_lr;
    logic [4:0]  r_sh;
    logic [31:0] r_d;
    int          sel;
    checks   = 0;
    failures = 0;
    bus.start    = 1'b0;
    bus.lr_shift = 1'b0;
    bus.shamt    = '0;
    bus.data_in  = '0;

    vecs[0]  = '{1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000, 32, 0, 1'b0};
    vecs[1]  = '{1'b1, 5'd4,  32'h8000_0000, 32'hF800_0000, 5, 0, 1'b0};
    vecs[2]  = '{1'b1, 5'd4,  32'h7000_0000, 32'h0700_0000, 5, 0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1'b0};
    vecs[4]  = '{1'b0, 5'd10, 32'h0000_0001, 32'h0000_0400, 11, 3, 1'b1};
    vecs[5]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EE ? 2 : 32, 0, 1'b0};
    vecs[6]  = '{1'b0, 5'd7,  32'h0000_0000, 32'h0000_0000, EE ? 2 : 8, 0, 1'b0};
    vecs[7]  = '{1'b1, 5'd31, 32'hF000_0000, 32'hFFFF_FFFF, EE ? 30 : 32, 0, 1'b0};
    vecs[8]  = '{1'b0, 5'd3,  32'h8000_0001, 32'h0000_0008, 4, 0, 1'b0};
    vecs[9]  = '{1'b0, 5'd28, 32'h0000_00F0, 32'h0000_0000, 29, 0, 1'b0};
    vecs[10] = '{1'b1, 5'd31, 32'h4000_0000, 32'h0000_0000, 32, 0, 1'b0};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset result", bus.result, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].lr, vecs[i].sh, vecs[i].din,
             vecs[i].exp_res, vecs[i].exp_lat, vecs[i].pulse_cyc, vecs[i].start_in_done);
    end

    // asynchronous reset in cycle 4 of a 20-bit shift
    @(negedge clock);
    bus.start = 1'b1; bus.lr_shift = 1'b0; bus.shamt = 5'd20; bus.data_in = 32'h0000_0005;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midreset result", bus.result, 32'h0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    run_op("after_reset", 1'b0, 5'd1, 32'h0000_0003, 32'h0000_0006, 2, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 5);
      r_lr = 1'($urandom_range(0, 1));
      r_sh = 5'($urandom_range(0, 31));
      case (sel)
        0: r_d = 32'h0;
        1: r_d = 32'hFFFF_FFFF;
        2: r_d = 32'h8000_0000 | ($urandom >> $urandom_range(0, 31));
        default: r_d = $urandom;
      endcase
      run_op($sformatf("rand%0d", n), r_lr, r_sh, r_d, model_result(r_lr, int'(r_sh), r_d),
             model_latency(r_lr, int'(r_sh), r_d), 0, 1'b0);
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
